// File: rtl/trap_ctrl.sv
// trap_ctrl: interrupt/exception controller for the MIPS pipeline.
// It latches IRQ rising edges into pending bits and gates them with a mask.
// An illegal opcode beats every IRQ; among IRQs the lowest index wins.
// A trap is offered to the pipeline with a req/ack handshake.
// The block owns the kernel-mode bit and latches the cause and EPC of the taken trap.
// Optional feature: define TRAP_CNT_EN to add a saturating 16-bit trap_count output.
module trap_ctrl #(
   parameter int unsigned     NUM_IRQ = 4,
   parameter int unsigned     PC_W    = 32,
   parameter logic [PC_W-1:0] IRQ_VEC = 32'h80000004,
   parameter logic [PC_W-1:0] EXC_VEC = 32'h80000008,
   localparam int unsigned    CW      = $clog2(NUM_IRQ) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               illegal_op,
   input  logic               instr_valid,
   input  logic [PC_W-1:0]    resume_pc,
   input  logic               trap_ack,
   input  logic               eret,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   output logic               trap_req,
   output logic [PC_W-1:0]    trap_vec,
   output logic               ker,
   output logic [CW-1:0]      cause,
   output logic [PC_W-1:0]    epc,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask,
`ifdef TRAP_CNT_EN
   output logic [15:0]        trap_count,
`endif
   output logic               double_fault
);

   // Index width; at least one bit, so a single-channel build stays legal.
   localparam int unsigned IW = (CW > 1) ? CW - 1 : 1;
   localparam logic [CW-1:0] EXC_CAUSE = CW'(1) << (CW - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_KERNEL
   } state_t;

   state_t             r_state;
   logic               r_trap_req;
   logic               r_ker;
   logic [CW-1:0]      r_cause;
   logic [PC_W-1:0]    r_epc;
   logic [NUM_IRQ-1:0] r_pending;
   logic [NUM_IRQ-1:0] r_mask;
   logic [NUM_IRQ-1:0] r_irq_q;
   logic [NUM_IRQ-1:0] r_take;    // one-hot channel to clear on ack; zero for exceptions
   logic               r_double_fault;
`ifdef TRAP_CNT_EN
   logic [15:0]        r_trap_count;
`endif

   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_elig;
   logic [NUM_IRQ-1:0] w_onehot;
   logic [NUM_IRQ-1:0] w_clr;
   logic [IW-1:0]      w_idx;
   logic               w_hit;
   logic               w_exc;
   logic               w_ack;

   assign w_rise = irq & ~r_irq_q;
   assign w_elig = r_pending & r_mask;
   assign w_exc  = illegal_op & instr_valid;
   assign w_ack  = (r_state == S_REQ) && trap_ack;
   assign w_clr  = w_ack ? r_take : '0;

   // Pick the lowest-index eligible IRQ channel.
   always_comb begin
      w_idx    = '0;
      w_hit    = 1'b0;
      w_onehot = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (w_elig[i] && !w_hit) begin
            w_hit       = 1'b1;
            w_idx       = IW'(i);
            w_onehot[i] = 1'b1;
         end
      end
   end

   // Edge capture, pending set/clear (set wins) and mask register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_q   <= '0;
         r_pending <= '0;
         r_mask    <= '1;
      end else begin
         r_irq_q   <= irq;
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (mask_we) begin
            r_mask <= mask_wdata;
         end
      end
   end

   // Trap FSM: pick a source in IDLE, hold the request until ack, run the handler until eret.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_trap_req     <= 1'b0;
         r_ker          <= 1'b0;
         r_cause        <= '0;
         r_epc          <= '0;
         r_take         <= '0;
         r_double_fault <= 1'b0;
`ifdef TRAP_CNT_EN
         r_trap_count   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_exc) begin
                  r_state    <= S_REQ;
                  r_trap_req <= 1'b1;
                  r_cause    <= EXC_CAUSE;
                  r_take     <= '0;
               end else if (w_hit) begin
                  r_state    <= S_REQ;
                  r_trap_req <= 1'b1;
                  r_cause    <= CW'(w_idx);
                  r_take     <= w_onehot;
               end
            end
            S_REQ: begin
               if (trap_ack) begin
                  r_state    <= S_KERNEL;
                  r_trap_req <= 1'b0;
                  r_ker      <= 1'b1;
                  r_epc      <= resume_pc;
`ifdef TRAP_CNT_EN
                  if (r_trap_count != '1) begin
                     r_trap_count <= r_trap_count + 16'd1;
                  end
`endif
               end
            end
            S_KERNEL: begin
               if (w_exc) begin
                  r_double_fault <= 1'b1;
               end
               if (eret) begin
                  r_state <= S_IDLE;
                  r_ker   <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_trap_req <= 1'b0;
               r_ker      <= 1'b0;
            end
         endcase
      end
   end

   // Handler address is decoded live from state and cause.
   always_comb begin
      trap_vec = '0;
      if (r_state == S_REQ) begin
         trap_vec = r_cause[CW-1] ? EXC_VEC : IRQ_VEC;
      end
   end

   assign trap_req     = r_trap_req;
   assign ker          = r_ker;
   assign cause        = r_cause;
   assign epc          = r_epc;
   assign pending      = r_pending;
   assign mask         = r_mask;
   assign double_fault = r_double_fault;
`ifdef TRAP_CNT_EN
   assign trap_count   = r_trap_count;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: bench for trap_ctrl with NUM_IRQ=4.
// The reference model tracks two booleans, "request outstanding" and "in handler".
// It computes the winning channel by isolating the lowest set bit.
// The directed test plan runs first, followed by randomized traffic.
module tb_trap_ctrl;
   localparam int N  = 4;
   localparam int CW = 3;
   localparam logic [31:0] IRQ_V = 32'h80000004;
   localparam logic [31:0] EXC_V = 32'h80000008;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  irq;
   logic          illegal_op, instr_valid, trap_ack, eret, mask_we;
   logic [31:0]   resume_pc;
   logic [N-1:0]  mask_wdata;
   logic          trap_req, ker, double_fault;
   logic [31:0]   trap_vec, epc;
   logic [CW-1:0] cause;
   logic [N-1:0]  pending, mask;
`ifdef TRAP_CNT_EN
   logic [15:0]   trap_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit            m_req, m_in_handler, m_df;
   logic [CW-1:0] m_cause;
   logic [31:0]   m_epc;
   logic [N-1:0]  m_pend, m_mask, m_irq_prev;
   int            m_taken;   // channel of outstanding trap, -1 for exception
   int unsigned   m_cnt;

   trap_ctrl #(.NUM_IRQ(N), .PC_W(32), .IRQ_VEC(IRQ_V), .EXC_VEC(EXC_V)) dut (
      .clk(clk), .reset(reset), .irq(irq), .illegal_op(illegal_op),
      .instr_valid(instr_valid), .resume_pc(resume_pc), .trap_ack(trap_ack),
      .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .trap_req(trap_req), .trap_vec(trap_vec), .ker(ker), .cause(cause),
      .epc(epc), .pending(pending), .mask(mask),
`ifdef TRAP_CNT_EN
      .trap_count(trap_count),
`endif
      .double_fault(double_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the specified behaviour, using the inputs present before the edge.
   task automatic model_step();
      logic [N-1:0] rise, elig, iso, clr;
      if (reset) begin
         m_req = 0; m_in_handler = 0; m_df = 0; m_cause = '0; m_epc = '0;
         m_pend = '0; m_mask = '1; m_irq_prev = '0; m_taken = -1; m_cnt = 0;
         return;
      end
      rise = irq & ~m_irq_prev;
      elig = m_pend & m_mask;
      iso  = elig & (~elig + 1'b1);
      clr  = '0;
      if (!m_req && !m_in_handler) begin
         if (illegal_op && instr_valid) begin
            m_req = 1; m_cause = 3'b100; m_taken = -1;
         end else if (elig != 0) begin
            m_req = 1; m_taken = $clog2(iso); m_cause = CW'(m_taken);
         end
      end else if (m_req) begin
         if (trap_ack) begin
            m_req = 0; m_in_handler = 1; m_epc = resume_pc;
            if (m_taken >= 0) clr[m_taken] = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end
      end else begin
         if (illegal_op && instr_valid) m_df = 1;
         if (eret) m_in_handler = 0;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (mask_we) m_mask = mask_wdata;
      m_irq_prev = irq;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("trap_req", 64'(trap_req), 64'(m_req));
      check("trap_vec", 64'(trap_vec), m_req ? 64'(m_cause[CW-1] ? EXC_V : IRQ_V) : 64'd0);
      check("ker", 64'(ker), 64'(m_in_handler));
      check("cause", 64'(cause), 64'(m_cause));
      check("epc", 64'(epc), 64'(m_epc));
      check("pending", 64'(pending), 64'(m_pend));
      check("mask", 64'(mask), 64'(m_mask));
      check("double_fault", 64'(double_fault), 64'(m_df));
`ifdef TRAP_CNT_EN
      check("trap_count", 64'(trap_count), 64'(m_cnt));
`endif
   endtask

   task automatic quiet();
      reset = 0; irq = '0; illegal_op = 0; instr_valid = 1; trap_ack = 0;
      eret = 0; mask_we = 0; mask_wdata = '0; resume_pc = 32'h00400000;
   endtask

   // Full trap on one channel: pulse, request, ack, return.
   task automatic do_trap(input int ch);
      irq[ch] = 1'b1; cycle();
      irq[ch] = 1'b0; cycle();
      check("dt_req", 64'(trap_req), 64'd1);
      trap_ack = 1; cycle(); trap_ack = 0;
      eret = 1; cycle(); eret = 0;
   endtask

   initial begin
      m_req = 0; m_in_handler = 0; m_df = 0; m_cause = '0; m_epc = '0;
      m_pend = '0; m_mask = '1; m_irq_prev = '0; m_taken = -1; m_cnt = 0;
      quiet();
      reset = 1; cycle(); cycle();
      reset = 0;
      check("rst_req", 64'(trap_req), 64'd0);
      check("rst_mask", 64'(mask), 64'hF);

      // single IRQ on channel 2
      irq = 4'b0100; cycle();
      check("p1_pend", 64'(pending), 64'h4);
      check("p1_req_early", 64'(trap_req), 64'd0);
      irq = '0; cycle();
      check("p1_req", 64'(trap_req), 64'd1);
      check("p1_vec", 64'(trap_vec), 64'h80000004);
      resume_pc = 32'h00400010; trap_ack = 1; cycle(); trap_ack = 0;
      check("p1_ker", 64'(ker), 64'd1);
      check("p1_epc", 64'(epc), 64'h00400010);
      check("p1_cause", 64'(cause), 64'b010);
      check("p1_pend0", 64'(pending), 64'h0);
      trap_ack = 1; cycle(); trap_ack = 0;            // ack outside REQ ignored
      eret = 1; cycle(); eret = 0;

      // simultaneous channels 1 and 3
      irq = 4'b1010; cycle();
      irq = '0; cycle();
      check("p2_cause", 64'(cause), 64'b001);
      trap_ack = 1; cycle(); trap_ack = 0;
      eret = 1; cycle(); eret = 0;
      check("p2_idle", 64'(trap_req), 64'd0);
      cycle();
      check("p2_cause2", 64'(cause), 64'b011);
      check("p2_req2", 64'(trap_req), 64'd1);
      trap_ack = 1; cycle(); trap_ack = 0;
      eret = 1; cycle(); eret = 0;

      // exception beats pending IRQ 0
      irq = 4'b0001; cycle();
      irq = '0; illegal_op = 1; cycle(); illegal_op = 0;
      check("p3_cause", 64'(cause), 64'b100);
      check("p3_vec", 64'(trap_vec), 64'h80000008);
      trap_ack = 1; cycle(); trap_ack = 0;
      check("p3_pend", 64'(pending), 64'h1);
      eret = 1; cycle(); eret = 0;
      cycle();
      check("p3_cause2", 64'(cause), 64'b000);
      trap_ack = 1; cycle(); trap_ack = 0;
      eret = 1; cycle(); eret = 0;

      // masked channel 0 waits until unmasked
      mask_we = 1; mask_wdata = 4'b1110; cycle(); mask_we = 0;
      irq = 4'b0001; cycle(); irq = '0;
      for (int i = 0; i < 20; i++) cycle();
      check("p4_noreq", 64'(trap_req), 64'd0);
      check("p4_pend", 64'(pending), 64'h1);
      mask_we = 1; mask_wdata = 4'b1111; cycle(); mask_we = 0;
      check("p4_req_early", 64'(trap_req), 64'd0);
      cycle();
      check("p4_req", 64'(trap_req), 64'd1);
      trap_ack = 1; cycle(); trap_ack = 0;

      // exception while in the handler
      illegal_op = 1; cycle(); illegal_op = 0;
      check("p5_df", 64'(double_fault), 64'd1);
      check("p5_ker", 64'(ker), 64'd1);
      eret = 1; cycle(); eret = 0;
      check("p5_df_sticky", 64'(double_fault), 64'd1);

      // reset in the middle of a request
      irq = 4'b0100; cycle(); irq = '0; cycle();
      check("p6_req", 64'(trap_req), 64'd1);
      reset = 1; cycle(); reset = 0;
      check("p6_req0", 64'(trap_req), 64'd0);
      check("p6_df0", 64'(double_fault), 64'd0);
      check("p6_epc0", 64'(epc), 64'd0);
      check("p6_vec0", 64'(trap_vec), 64'd0);

`ifdef TRAP_CNT_EN
      for (int k = 0; k < 3; k++) do_trap(k);
      check("cnt3", 64'(trap_count), 64'd3);
      dut.r_trap_count = 16'hFFFD; m_cnt = 16'hFFFD;
      for (int k = 0; k < 4; k++) do_trap(3);
      check("cnt_sat", 64'(trap_count), 64'hFFFF);
`else
      do_trap(1);
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset       = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 3) == 0) irq = irq ^ N'($urandom);
         illegal_op  = ($urandom_range(0, 19) == 0);
         instr_valid = ($urandom_range(0, 3) != 0);
         trap_ack    = ($urandom_range(0, 2) == 0);
         eret        = ($urandom_range(0, 4) == 0);
         mask_we     = ($urandom_range(0, 24) == 0);
         mask_wdata  = N'($urandom);
         resume_pc   = $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised interrupt/exception controller for the MIPS CPU.
- Generalises the single-IRQ, kernel-bit-input trap logic of the instruction control unit:
  - N edge-latched IRQ channels, with a mask and fixed priority.
  - Kernel-mode state owned by the block.
  - Request/acknowledge handshake with the pipeline.
  - Latched cause and EPC.
- Sits beside the decode/control stage. The pipeline flushes and redirects its PC on trap_req/trap_ack.

Parameters:
- NUM_IRQ, 4, number of IRQ channels (1..16).
- PC_W, 32, PC width.
- IRQ_VEC, 32'h80000004, handler address for interrupts.
- EXC_VEC, 32'h80000008, handler address for exceptions (illegal opcode).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  NUM_IRQ  interrupt lines, rising-edge sensitive.
- illegal_op  in  1  decoder flags an undefined opcode/funct.
- instr_valid  in  1  decode slot holds a real instruction (not a bubble).
- resume_pc  in  PC_W  PC at which to resume; sampled on acknowledge.
- trap_ack  in  1  pipeline has flushed and redirected to trap_vec.
- eret  in  1  handler return executed.
- mask_we  in  1  write the mask register.
- mask_wdata  in  NUM_IRQ  new mask value (1 = enabled).
- trap_req  out  1  trap pending toward the pipeline.
- trap_vec  out  PC_W  handler address while trap_req is high.
- ker  out  1  kernel mode.
- cause  out  CW  latched cause. CW = $clog2(NUM_IRQ)+1. MSB=1 means exception; otherwise the low bits are the IRQ index.
- epc  out  PC_W  saved return PC.
- pending  out  NUM_IRQ  latched pending bits.
- mask  out  NUM_IRQ  current mask.
- double_fault  out  1  sticky flag: exception raised while in kernel mode.

Behaviour:
- Reset values:
  - State IDLE.
  - trap_req=0, ker=0, cause=0, epc=0, pending=0, double_fault=0.
  - mask = all ones.
  - Internal irq_q = 0.
  - Reset mid-handshake or mid-handler drops straight to IDLE.
- Edge capture:
  - irq_q <= irq each cycle.
  - pending[i] is set at the edge where irq[i] & ~irq_q[i].
  - pending[i] is cleared on acknowledge of channel i.
  - If set and clear coincide on one channel, set wins.
- Mask:
  - mask_we loads mask_wdata at the edge.
  - Masking does not clear pending; a masked pending bit is taken once unmasked.
- Priority:
  - An exception beats any IRQ.
  - Among IRQs, the lowest index wins.
  - Eligible IRQ set = pending & mask.
- FSM states: IDLE, REQ, KERNEL.
- IDLE:
  - If illegal_op & instr_valid: go to REQ, cause={1,0}. Latency 1 edge.
  - Else if (pending & mask) is nonzero: go to REQ, cause={0,idx} of the highest-priority channel.
  - irq rise to trap_req high = 2 edges.
- REQ:
  - trap_req=1.
  - trap_vec = EXC_VEC if cause MSB is set, else IRQ_VEC.
  - Cause is frozen: new IRQs or exceptions never preempt.
  - eret is ignored.
  - On trap_ack: go to KERNEL; ker<=1; epc<=resume_pc; clear the taken pending bit (IRQ case only).
  - trap_req holds indefinitely until trap_ack.
- KERNEL:
  - ker=1 and IRQs are not taken; pending bits keep accumulating.
  - illegal_op & instr_valid sets double_fault; the state is unchanged.
  - eret: go to IDLE, ker<=0.
  - If eret and a new eligible source coincide, go to IDLE first; REQ follows on the next edge.
- Outputs are registered except trap_vec, which is decoded from state and cause.
- trap_ack outside REQ is ignored.
- trap_vec = 0 when not in REQ.
- double_fault clears only on reset.

Optional Feature:
- Macro: TRAP_CNT_EN.
- Defined:
  - Adds output trap_count [15:0].
  - Increments on every acknowledge and saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- NUM_IRQ=4. Pulse irq[2] at cycle 0 -> pending=4'b0100 after edge 1, trap_req=1 after edge 2, trap_vec=32'h80000004. trap_ack with resume_pc=32'h00400010 -> ker=1, epc=32'h00400010, cause=3'b010, pending=0.
- irq[1] and irq[3] rise together -> cause=3'b001. After ack and eret -> second trap with cause=3'b011.
- illegal_op=1, instr_valid=1 in the same cycle as pending irq[0] -> cause=3'b100, trap_vec=32'h80000008, and pending[0] stays set after ack.
- mask_wdata=4'b1110, then pulse irq[0] -> no trap_req for 20 cycles, pending[0]=1. Then write mask=4'b1111 -> trap_req two edges later.
- In KERNEL, assert illegal_op & instr_valid -> double_fault=1, state unchanged. Assert reset for 1 cycle mid-REQ -> all outputs at reset values.
- With TRAP_CNT_EN defined: 3 acknowledged traps -> trap_count=3. Preload near saturation -> holds at 16'hFFFF.
